// File: rtl/instq_pkg.sv
// Shared definitions for the instruction queue: word width, field bit positions
// and the decoded field bundle handed to the control unit.
package instq_pkg;

    localparam int INST_W       = 18;
    localparam int OP_W         = 3;
    localparam int REG_W        = 3;
    localparam int IMM_W        = 8;
    localparam int ADDR_FIELD_W = 12;

    // Bit 17 selects where the function code lives.
    localparam int FUNC_SEL_BIT = 17;

    localparam int OP_MSB      = 17;
    localparam int OP_LSB      = 15;
    localparam int FUNC_HI_MSB = 16;
    localparam int FUNC_HI_LSB = 14;
    localparam int FUNC_LO_MSB = 2;
    localparam int FUNC_LO_LSB = 0;
    localparam int ADDR_MSB    = 11;
    localparam int ADDR_LSB    = 0;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;
    localparam int RS_MSB      = 10;
    localparam int RS_LSB      = 8;
    localparam int RS2_MSB     = 7;
    localparam int RS2_LSB     = 5;
    localparam int RD_MSB      = 13;
    localparam int RD_LSB      = 11;
    localparam int CNT_MSB     = 7;
    localparam int CNT_LSB     = 5;

    typedef struct packed {
        logic [OP_W-1:0]         op;
        logic [REG_W-1:0]        func;
        logic [ADDR_FIELD_W-1:0] addr;
        logic [IMM_W-1:0]        disp;
        logic [IMM_W-1:0]        offset;
        logic [REG_W-1:0]        rs;
        logic [REG_W-1:0]        rs2;
        logic [REG_W-1:0]        rd;
        logic [IMM_W-1:0]        immed;
        logic [REG_W-1:0]        count;
    } inst_fields_t;

endpackage

// File: rtl/instq_split_if.sv
// Fetch-side push handshake and decode-side consume handshake of instq_split.
// master = fetch stage / control unit side, slave = the queue.
interface instq_split_if #(
    parameter int ADDR_W = 12
);
    import instq_pkg::*;

    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] pc_i;
    logic              inst_valid_i;
    logic              inst_ready_o;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [ADDR_W-1:0] dec_pc_o;

    modport master (
        output inst_i, pc_i, inst_valid_i, dec_ready_i,
        input  inst_ready_o, dec_valid_o, dec_pc_o
    );

    modport slave (
        input  inst_i, pc_i, inst_valid_i, dec_ready_i,
        output inst_ready_o, dec_valid_o, dec_pc_o
    );

endinterface

// File: rtl/instq_field_split.sv
// Purely combinational slicer from an 18-bit instruction word to its fields.
// Shared with the control-unit bench model.
module instq_field_split
    import instq_pkg::*;
(
    input  logic [INST_W-1:0] word,
    output inst_fields_t      fields
);

    always_comb begin
        fields        = '0;
        fields.op     = word[OP_MSB:OP_LSB];
        fields.func   = word[FUNC_SEL_BIT] ? word[FUNC_LO_MSB:FUNC_LO_LSB]
                                           : word[FUNC_HI_MSB:FUNC_HI_LSB];
        fields.addr   = word[ADDR_MSB:ADDR_LSB];
        fields.disp   = word[IMM_MSB:IMM_LSB];
        fields.offset = word[IMM_MSB:IMM_LSB];
        fields.immed  = word[IMM_MSB:IMM_LSB];
        fields.rs     = word[RS_MSB:RS_LSB];
        fields.rs2    = word[RS2_MSB:RS2_LSB];
        fields.rd     = word[RD_MSB:RD_LSB];
        fields.count  = word[CNT_MSB:CNT_LSB];
    end

endmodule

// File: rtl/instq_split.sv
// Instruction queue with registered decode stage and field splitter.
// Optional build macro INSTQ_BYPASS_EN lets a push into an empty queue load the stage directly.
module instq_split
    import instq_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 12,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    instq_split_if.slave       bus,
    input  logic               flush_i,
    output logic [OP_W-1:0]    op_o,
    output logic [REG_W-1:0]   func_o,
    output logic [11:0]        addr_o,
    output logic [IMM_W-1:0]   disp_o,
    output logic [IMM_W-1:0]   offset_o,
    output logic [REG_W-1:0]   rs_o,
    output logic [REG_W-1:0]   rs2_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [IMM_W-1:0]   immed_o,
    output logic [REG_W-1:0]   count_o,
    output logic [LVL_W-1:0]   level_o
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              dec_valid_reg;
    logic [INST_W-1:0] dec_word_reg;
    logic [ADDR_W-1:0] dec_pc_reg;

    logic              inst_ready;
    logic              q_empty;
    logic              stage_free;
    logic              push;
    logic              bypass;
    logic              pop;
    logic              q_write;
    logic              load;
    entry_t            load_entry;
    inst_fields_t      fields;

    // Ready depends only on the level register, so no input reaches it combinationally.
    always_comb begin
        inst_ready = (level_reg != LVL_W'(DEPTH));
        q_empty    = (level_reg == '0);
        stage_free = !dec_valid_reg || bus.dec_ready_i;
        push       = bus.inst_valid_i && inst_ready && !flush_i;
`ifdef INSTQ_BYPASS_EN
        bypass     = push && q_empty && stage_free;
`else
        bypass     = 1'b0;
`endif
        pop        = stage_free && !q_empty && !flush_i;
        q_write    = push && !bypass;
        load       = pop || bypass;
        load_entry = mem[rd_ptr_reg];
        if (bypass) begin
            load_entry = '{inst: bus.inst_i, pc: bus.pc_i};
        end
    end

    // Queue storage is never reset; the decode stage register acts as its read register.
    always_ff @(posedge clk) begin
        if (q_write) begin
            mem[wr_ptr_reg] <= '{inst: bus.inst_i, pc: bus.pc_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            dec_valid_reg <= 1'b0;
            dec_word_reg  <= '0;
            dec_pc_reg    <= '0;
        end else if (flush_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            dec_valid_reg <= 1'b0;
        end else begin
            if (q_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({q_write, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            if (load) begin
                dec_valid_reg <= 1'b1;
                dec_word_reg  <= load_entry.inst;
                dec_pc_reg    <= load_entry.pc;
            end else if (bus.dec_ready_i) begin
                dec_valid_reg <= 1'b0;
            end
        end
    end

    instq_field_split u_field_split (
        .word   (dec_word_reg),
        .fields (fields)
    );

    assign bus.inst_ready_o = inst_ready;
    assign bus.dec_valid_o  = dec_valid_reg;
    assign bus.dec_pc_o     = dec_pc_reg;
    assign level_o          = level_reg;

    assign op_o     = fields.op;
    assign func_o   = fields.func;
    assign addr_o   = fields.addr;
    assign disp_o   = fields.disp;
    assign offset_o = fields.offset;
    assign rs_o     = fields.rs;
    assign rs2_o    = fields.rs2;
    assign rd_o     = fields.rd;
    assign immed_o  = fields.immed;
    assign count_o  = fields.count;

endmodule

// File: tb/tb_instq_split.sv
// Directed self-checking bench for instq_split (works with or without INSTQ_BYPASS_EN).
module tb_instq_split;
    import instq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
`ifdef INSTQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] op, func, rs, rs2, rd, count;
    logic [11:0] addr;
    logic [7:0] disp, offset, immed;
    logic [2:0] level;

    int checks = 0;
    int fails  = 0;

    instq_split_if #(.ADDR_W(ADDR_W)) bus ();

    instq_split #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush_i  (flush),
        .op_o     (op),
        .func_o   (func),
        .addr_o   (addr),
        .disp_o   (disp),
        .offset_o (offset),
        .rs_o     (rs),
        .rs2_o    (rs2),
        .rd_o     (rd),
        .immed_o  (immed),
        .count_o  (count),
        .level_o  (level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.inst_i = '0; bus.pc_i = '0; bus.inst_valid_i = 1'b0; bus.dec_ready_i = 1'b1;
        repeat (2) tick();
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid_o); end
        checks++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (bus.inst_ready_o !== 1'b1) begin fails++; $display("FAIL reset_inst_ready: got %b want 1", bus.inst_ready_o); end
        checks++; if ({op, func, addr, immed, rd} !== 29'd0) begin fails++; $display("FAIL reset_fields: got %h want 0", {op, func, addr, immed, rd}); end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_basic;
        bus.dec_ready_i = 1'b0;
        bus.inst_i = 18'h2A5C3; bus.pc_i = 12'h010; bus.inst_valid_i = 1'b1;
        tick();
        bus.inst_valid_i = 1'b0;
        checks++; if (bus.dec_valid_o !== BYP) begin fails++; $display("FAIL basic_valid_edgeN: got %b want %b", bus.dec_valid_o, BYP); end
        checks++; if (level !== {2'b00, ~BYP}) begin fails++; $display("FAIL basic_level_edgeN: got %0d want %0d", level, {2'b00, ~BYP}); end
        tick();
        checks++; if (bus.dec_valid_o !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bus.dec_valid_o); end
        checks++; if (level !== 3'd0) begin fails++; $display("FAIL basic_level: got %0d want 0", level); end
        checks++; if (op !== 3'd5) begin fails++; $display("FAIL basic_op: got %0d want 5", op); end
        checks++; if (func !== 3'd3) begin fails++; $display("FAIL basic_func: got %0d want 3", func); end
        checks++; if (addr !== 12'h5C3) begin fails++; $display("FAIL basic_addr: got %h want 5c3", addr); end
        checks++; if ({rs, rs2, rd} !== {3'd5, 3'd6, 3'd4}) begin fails++; $display("FAIL basic_regs: got rs=%0d rs2=%0d rd=%0d want 5 6 4", rs, rs2, rd); end
        checks++; if ({immed, disp, offset} !== {3{8'hC3}}) begin fails++; $display("FAIL basic_imm: got %h %h %h want c3", immed, disp, offset); end
        checks++; if (count !== 3'd6) begin fails++; $display("FAIL basic_count: got %0d want 6", count); end
        checks++; if (bus.dec_pc_o !== 12'h010) begin fails++; $display("FAIL basic_pc: got %h want 010", bus.dec_pc_o); end
        $display("tx pc=%h op=%0d func=%0d", bus.dec_pc_o, op, func);
        bus.dec_ready_i = 1'b1;
        tick();
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL basic_consumed: got %b want 0", bus.dec_valid_o); end
    endtask

    task automatic test_func_select;
        bus.dec_ready_i = 1'b0;
        bus.inst_i = 18'h04000; bus.pc_i = 12'h020; bus.inst_valid_i = 1'b1;
        tick();
        bus.inst_valid_i = 1'b0;
        tick();
        checks++; if (op !== 3'd0) begin fails++; $display("FAIL func_op: got %0d want 0", op); end
        checks++; if (func !== 3'd1) begin fails++; $display("FAIL func_hi: got %0d want 1", func); end
        checks++; if (bus.dec_pc_o !== 12'h020) begin fails++; $display("FAIL func_pc: got %h want 020", bus.dec_pc_o); end
        $display("tx pc=%h op=%0d func=%0d", bus.dec_pc_o, op, func);
        bus.dec_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_back_pressure;
        bus.dec_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.inst_i = 18'(k << 8); bus.pc_i = 12'(12'h100 + k); bus.inst_valid_i = 1'b1;
            tick();
            if (k >= 2) begin
                checks++; if (level !== 3'(k)) begin fails++; $display("FAIL bp_level_fill%0d: got %0d want %0d", k, level, k); end
            end
            checks++; if (bus.inst_ready_o !== (k < 4)) begin fails++; $display("FAIL bp_ready%0d: got %b want %b", k, bus.inst_ready_o, (k < 4)); end
        end
        bus.pc_i = 12'h1FF; bus.inst_i = 18'h3FFFF;
        tick();
        bus.inst_valid_i = 1'b0;
        checks++; if (level !== 3'd4) begin fails++; $display("FAIL bp_full_hold: got %0d want 4", level); end
        checks++; if (bus.dec_pc_o !== 12'h100) begin fails++; $display("FAIL bp_stage_hold: got %h want 100", bus.dec_pc_o); end
        bus.dec_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++; if (bus.dec_pc_o !== 12'(12'h100 + k)) begin fails++; $display("FAIL bp_order%0d: got %h want %h", k, bus.dec_pc_o, 12'(12'h100 + k)); end
            checks++; if (level !== 3'(4 - k)) begin fails++; $display("FAIL bp_drain%0d: got %0d want %0d", k, level, 4 - k); end
            checks++; if (rs !== 3'(k)) begin fails++; $display("FAIL bp_rs%0d: got %0d want %0d", k, rs, k); end
            $display("tx pc=%h level=%0d", bus.dec_pc_o, level);
        end
        tick();
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL bp_no_extra: got %b want 0", bus.dec_valid_o); end
    endtask

    task automatic test_wrap;
        int idx = 0;
        int got = 0;
        logic accepted;
        bus.dec_ready_i = 1'b1;
        bus.inst_i = 18'h00000; bus.pc_i = 12'h200; bus.inst_valid_i = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            accepted = bus.inst_valid_i && bus.inst_ready_o;
            tick();
            if (accepted) idx++;
            bus.inst_valid_i = (idx < 10);
            bus.pc_i = 12'(12'h200 + idx); bus.inst_i = 18'(idx);
            if (bus.dec_valid_o === 1'b1) begin
                checks++; if (bus.dec_pc_o !== 12'(12'h200 + got)) begin fails++; $display("FAIL wrap_pc%0d: got %h want %h", got, bus.dec_pc_o, 12'(12'h200 + got)); end
                $display("tx pc=%h", bus.dec_pc_o);
                got++;
            end
        end
        bus.inst_valid_i = 1'b0;
        checks++; if (got !== 10) begin fails++; $display("FAIL wrap_count: got %0d want 10", got); end
        tick();
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL wrap_no_dup: got %b want 0", bus.dec_valid_o); end
    endtask

    task automatic test_flush;
        bus.dec_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.inst_i = 18'(k); bus.pc_i = 12'(12'h300 + k); bus.inst_valid_i = 1'b1;
            tick();
        end
        checks++; if (level !== 3'd3) begin fails++; $display("FAIL flush_pre_level: got %0d want 3", level); end
        checks++; if (bus.dec_valid_o !== 1'b1) begin fails++; $display("FAIL flush_pre_valid: got %b want 1", bus.dec_valid_o); end
        bus.pc_i = 12'h3EE; flush = 1'b1;
        tick();
        checks++; if (level !== 3'd0) begin fails++; $display("FAIL flush_level: got %0d want 0", level); end
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.dec_valid_o); end
        flush = 1'b0; bus.inst_valid_i = 1'b0; bus.dec_ready_i = 1'b1;
        tick();
        checks++; if ({bus.dec_valid_o, level} !== 4'd0) begin fails++; $display("FAIL flush_dropped: got valid=%b level=%0d want 0 0", bus.dec_valid_o, level); end
        bus.dec_ready_i = 1'b0; bus.pc_i = 12'h3AA; bus.inst_valid_i = 1'b1;
        tick();
        bus.inst_valid_i = 1'b0;
        tick();
        checks++; if (bus.dec_pc_o !== 12'h3AA || bus.dec_valid_o !== 1'b1) begin fails++; $display("FAIL flush_resume: got pc=%h valid=%b want 3aa 1", bus.dec_pc_o, bus.dec_valid_o); end
        $display("tx pc=%h after flush", bus.dec_pc_o);
        bus.dec_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_async_reset;
        bus.dec_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.inst_i = 18'h2A5C3; bus.pc_i = 12'(12'h400 + k); bus.inst_valid_i = 1'b1;
            tick();
        end
        bus.inst_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dec_valid_o !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", bus.dec_valid_o); end
        checks++; if (level !== 3'd0) begin fails++; $display("FAIL areset_level: got %0d want 0", level); end
        checks++; if (bus.inst_ready_o !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", bus.inst_ready_o); end
        checks++; if ({op, addr, immed, rs, bus.dec_pc_o} !== 38'd0) begin fails++; $display("FAIL areset_fields: got %h want 0", {op, addr, immed, rs, bus.dec_pc_o}); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        bus.inst_i = 18'h2A5C3; bus.pc_i = 12'h7FF; bus.inst_valid_i = 1'b1;
        tick();
        bus.inst_valid_i = 1'b0;
        tick();
        checks++; if ({bus.dec_valid_o, op, bus.dec_pc_o} !== {1'b1, 3'd5, 12'h7FF}) begin fails++; $display("FAIL areset_resume: got valid=%b op=%0d pc=%h want 1 5 7ff", bus.dec_valid_o, op, bus.dec_pc_o); end
        $display("tx pc=%h after reset", bus.dec_pc_o);
        bus.dec_ready_i = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_func_select();
        test_back_pressure();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
